bp_fe_realigner_wide: RTL
=========================

Name: bp_fe_realigner_wide

Overview:
- Multi-parcel fetch realigner and instruction extractor between a wide I$ fetch port and the FE instruction queue.
- Accepts fetch blocks of fetch_width_p bits, which may start mid-block, and stores them as 16-bit parcels in a circular parcel buffer.
- Emits one RV64GC instruction per cycle: compressed (16b) or full (32b), including 32b instructions straddling block boundaries.
- Supports backend redirect, both flush and resume-with-partial-parcel.

Parameters:
vaddr_width_p, 39, virtual address width
fetch_width_p, 64, fetch block width in bits; power of 2, >=32; fetch_cells_p = fetch_width_p/16
buf_cells_p, 8, parcel buffer depth; power of 2, >= 2*fetch_cells_p

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
fetch_v_i  in  1  fetch block valid
fetch_ready_o  out  1  block accepted when fetch_v_i & fetch_ready_o
fetch_pc_i  in  vaddr_width_p  PC of first useful parcel; 2B-aligned
fetch_data_i  in  fetch_width_p  naturally aligned fetch block; parcel k = bits [16k+:16]
redirect_v_i  in  1  backend redirect
redirect_resume_i  in  1  restore one partial parcel (meaningful only with redirect_v_i)
redirect_partial_i  in  16  lower half of the straddling instruction
redirect_vaddr_i  in  vaddr_width_p  PC of the parcel following the partial
instr_v_o  out  1  instruction valid
instr_o  out  32  instruction; upper 16 bits zero when compressed
instr_pc_o  out  vaddr_width_p  instruction PC
instr_compressed_o  out  1  instr[1:0] != 2'b11
instr_partial_o  out  1  halves came from different blocks or from the resume parcel
instr_yumi_i  in  1  consumer takes instruction; legal only when instr_v_o

Behaviour:
- State: parcel RAM (buf_cells_p x 16), per-parcel block-start bit, rd/wr pointers (log2 buf_cells_p bits, wrap modulo depth), count (0..buf_cells_p), head_pc.
- Reset: count=0, pointers=0, head_pc=0, parcels cleared. Outputs after reset: instr_v_o=0, instr_o=0, instr_pc_o=0, flags=0. fetch_ready_o=0 during reset and 1 on the first cycle after reset.
- fetch_ready_o = ~reset_i & ~redirect_v_i & (buf_cells_p - count >= fetch_cells_p). Computed from registered count only; same-cycle dequeue does not increase free space.
- Enqueue, on fetch_v_i & fetch_ready_o:
  - off = fetch_pc_i[log2(fetch_width_p/8)-1:1].
  - Parcels off..fetch_cells_p-1 are written at wr, wr+1, ...; n = fetch_cells_p - off.
  - Block-start bit is set on the first written parcel only.
  - If the buffer is empty, or drains to empty this cycle, head_pc <= fetch_pc_i.
  - Otherwise fetch_pc_i must equal head_pc + 2*count. This is a bench assertion; RTL does not check it.
- Extraction is combinational from the head:
  - p0 = buf[rd], p1 = buf[rd+1] (wraps).
  - Compressed: instr_v_o = count>=1. Full (p0[1:0]==2'b11): instr_v_o = count>=2.
  - instr_o = compressed ? {16'b0,p0} : {p1,p0}. instr_pc_o = head_pc.
  - instr_partial_o = ~compressed & start[rd+1].
- Dequeue on instr_yumi_i: rd += 1 (compressed) or 2, count decreases by the same amount, head_pc += 2 or 4.
- Simultaneous enqueue and dequeue: count_next = count + n - d.
- Redirect has highest priority; fetch_v_i and instr_yumi_i are ignored in that cycle. All pointers and count are cleared. Then:
  - Resume: parcel 0 <= redirect_partial_i with start=1, count <= 1, head_pc <= redirect_vaddr_i - 2, wr <= 1. The next enqueued block supplies the upper half, and instr_partial_o=1 for the rejoined instruction.
  - Flush: count <= 0.
  - In both cases instr_v_o=0 in the redirect cycle itself.
- A lone full-length lower half at the head (count==1, not compressed) holds instr_v_o=0 until the next block arrives.
- Reset mid-operation discards all buffered parcels, with the same values as power-on reset.
- No combinational path from fetch_v_i or instr_yumi_i to fetch_ready_o.

Test Plan:
- Aligned block, pc=0x1000, data=0x00000013_00000013 (two nops) -> instr 0x00000013 @0x1000 then @0x1004; compressed=0, partial=0.
- Mixed RVC, pc=0x2000, data=0x4501_00000013_0001: parcels 0x0001, 0x0013, 0x0000, 0x4501 -> c.nop 0x0001 @0x2000 (compressed=1); full 0x00000013 @0x2002; c.li 0x4501 @0x2006.
- Straddle: block @0x3000 whose parcel 3 = 0x0093, then block @0x3008 with parcel 0 = 0x0000 -> instr 0x00000093 @0x3006, partial=1; instr_v_o=0 until the second block is accepted.
- Mid-block entry, pc=0x4004 with fetch_width_p=64 -> only parcels 2,3 enqueued; count=2; first instr_pc_o=0x4004.
- Redirect resume: partial=0x0513, vaddr=0x5002, then block @0x5002 (after alignment to 0x5000) -> instr {parcel1,0x0513} @0x5000, partial=1. Flush mid-stream -> instr_v_o=0 next cycle, fetch_ready_o=1.
- Backpressure, buf_cells_p=8: hold yumi low, four blocks offered -> only two accepted (fetch_ready_o=0 at count=8). Then yumi every cycle -> pointer wrap with no data loss and PCs strictly sequential.

Source files
------------

// File: rtl/bp_fe_realigner_wide.sv
// Fetch realigner: buffers wide fetch blocks as 16-bit parcels and extracts one
// RV64GC instruction (compressed or full, possibly block-straddling) per cycle.
module bp_fe_realigner_wide #(
    parameter int vaddr_width_p = 39,
    parameter int fetch_width_p = 64,
    parameter int buf_cells_p   = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     fetch_v_i,
    output logic                     fetch_ready_o,
    input  logic [vaddr_width_p-1:0] fetch_pc_i,
    input  logic [fetch_width_p-1:0] fetch_data_i,
    input  logic                     redirect_v_i,
    input  logic                     redirect_resume_i,
    input  logic [15:0]              redirect_partial_i,
    input  logic [vaddr_width_p-1:0] redirect_vaddr_i,
    output logic                     instr_v_o,
    output logic [31:0]              instr_o,
    output logic [vaddr_width_p-1:0] instr_pc_o,
    output logic                     instr_compressed_o,
    output logic                     instr_partial_o,
    input  logic                     instr_yumi_i
);

    localparam int fetch_cells_lp = fetch_width_p / 16;
    localparam int byte_off_lp    = $clog2(fetch_width_p / 8);
    localparam int ptr_width_lp   = $clog2(buf_cells_p);
    localparam int cnt_width_lp   = ptr_width_lp + 1;

    typedef logic [ptr_width_lp-1:0]  ptr_t;
    typedef logic [cnt_width_lp-1:0]  cnt_t;
    typedef logic [vaddr_width_p-1:0] vaddr_t;

    logic [15:0]            parcel_r [buf_cells_p];
    logic [buf_cells_p-1:0] start_r;
    ptr_t                   rd_r;
    ptr_t                   wr_r;
    cnt_t                   count_r;
    vaddr_t                 head_pc_r;

    ptr_t                   rd_p1_s;
    logic [15:0]            p0_s;
    logic [15:0]            p1_s;
    logic                   is_c_s;
    logic [byte_off_lp-2:0] off_s;
    logic                   enq_s;
    logic                   deq_s;
    cnt_t                   enq_amt_s;
    cnt_t                   deq_amt_s;
    cnt_t                   count_next_s;
    logic                   drain_empty_s;

    assign rd_p1_s = rd_r + ptr_t'(1);
    assign p0_s    = parcel_r[rd_r];
    assign p1_s    = parcel_r[rd_p1_s];
    assign is_c_s  = (p0_s[1:0] != 2'b11);
    assign off_s   = fetch_pc_i[byte_off_lp-1:1];

    // Free space is judged on registered count only, so no yumi/fetch_v path reaches ready.
    assign fetch_ready_o = ~reset_i & ~redirect_v_i
                         & ((cnt_t'(buf_cells_p) - count_r) >= cnt_t'(fetch_cells_lp));

    // Head extraction and output formatting.
    always_comb begin
        instr_v_o = 1'b0;
        if (redirect_v_i) begin
            instr_v_o = 1'b0;
        end else if (is_c_s) begin
            instr_v_o = (count_r != cnt_t'(0));
        end else begin
            instr_v_o = (count_r >= cnt_t'(2));
        end
        instr_o            = is_c_s ? {16'h0000, p0_s} : {p1_s, p0_s};
        instr_pc_o         = head_pc_r;
        instr_compressed_o = is_c_s & (count_r != cnt_t'(0));
        instr_partial_o    = ~is_c_s & start_r[rd_p1_s];
    end

    // Enqueue/dequeue amounts and next occupancy.
    always_comb begin
        enq_s     = fetch_v_i & fetch_ready_o;
        deq_s     = instr_yumi_i & instr_v_o;
        enq_amt_s = cnt_t'(fetch_cells_lp) - cnt_t'(off_s);
        deq_amt_s = is_c_s ? cnt_t'(1) : cnt_t'(2);
        count_next_s = count_r;
        if (enq_s) begin
            count_next_s = count_next_s + enq_amt_s;
        end else begin
            count_next_s = count_next_s;
        end
        if (deq_s) begin
            count_next_s = count_next_s - deq_amt_s;
        end else begin
            count_next_s = count_next_s;
        end
        drain_empty_s = (count_r == (deq_s ? deq_amt_s : cnt_t'(0)));
    end

    // Parcel buffer, pointers, count and head PC.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < buf_cells_p; i++) begin
                parcel_r[i] <= 16'h0000;
            end
            start_r   <= '0;
            rd_r      <= '0;
            wr_r      <= '0;
            count_r   <= '0;
            head_pc_r <= '0;
        end else if (redirect_v_i) begin
            rd_r <= '0;
            if (redirect_resume_i) begin
                // The saved lower half becomes parcel 0; the next block completes it.
                parcel_r[0] <= redirect_partial_i;
                start_r[0]  <= 1'b1;
                wr_r        <= ptr_t'(1);
                count_r     <= cnt_t'(1);
                head_pc_r   <= redirect_vaddr_i - vaddr_t'(2);
            end else begin
                wr_r    <= '0;
                count_r <= '0;
            end
        end else begin
            if (enq_s) begin
                for (int k = 0; k < fetch_cells_lp; k++) begin
                    if (k >= int'(off_s)) begin
                        parcel_r[wr_r + ptr_t'(k) - ptr_t'(off_s)] <= fetch_data_i[16*k +: 16];
                        start_r[wr_r + ptr_t'(k) - ptr_t'(off_s)]  <= (k == int'(off_s));
                    end
                end
                wr_r <= wr_r + ptr_t'(enq_amt_s);
            end
            if (deq_s) begin
                rd_r <= rd_r + ptr_t'(deq_amt_s);
            end
            if (enq_s && drain_empty_s) begin
                head_pc_r <= fetch_pc_i;
            end else if (deq_s) begin
                head_pc_r <= head_pc_r + (vaddr_t'(deq_amt_s) << 1);
            end
            count_r <= count_next_s;
        end
    end

endmodule
